// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the return-address stack (RAS) slice.
//   RAS_ADDR_WIDTH    : default width of a return address / index port
//   RAS_DEPTH_DEFAULT : default number of stack entries (power of two)
//   ras_entry_t       : one stored return address at the default width
// Optional feature macro used by this slice: RISCV_RAS_BYPASS_EN
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int RAS_ADDR_WIDTH    = 64;
  localparam int RAS_DEPTH_DEFAULT = 16;

  typedef logic [RAS_ADDR_WIDTH-1:0] ras_entry_t;

endpackage

// File: rtl/riscv_ras_mem.sv
// -----------------------------------------------------------------------------
// riscv_ras_mem
// One-write / one-read register array holding the RAS entries. The read port
// is registered: o_rdata updates one cycle after i_re and holds otherwise.
// All entries and the read register clear asynchronously on nreset low.
//
// Ports:
//   clk, nreset       : clock (rising edge) and async active-low reset
//   i_we, i_waddr     : write strobe and entry index
//   i_wdata           : data written to mem[i_waddr]
//   i_re, i_raddr     : read strobe and entry index
//   o_rdata           : registered read data
//
// Macro RISCV_RAS_BYPASS_EN: when defined, a same-cycle write and read of the
// same index returns the new write data instead of the stored entry.
// -----------------------------------------------------------------------------
module riscv_ras_mem
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = RAS_ADDR_WIDTH,
  parameter int DEPTH      = RAS_DEPTH_DEFAULT,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  i_we,
  input  logic [PTR_WIDTH-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [PTR_WIDTH-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Read samples mem_q (pre-write contents), giving read-before-write
  // behaviour on an index collision unless the bypass is built in.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (i_we) begin
      mem_d[i_waddr] = i_wdata;
    end
    if (i_re) begin
      rdata_d = mem_q[i_raddr];
`ifdef RISCV_RAS_BYPASS_EN
      if (i_we && (i_waddr == i_raddr)) begin
        rdata_d = i_wdata;
      end
`else
`endif
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/riscv_ras_stack.sv
// -----------------------------------------------------------------------------
// riscv_ras_stack
// Indexed return-address stack. The RAS arbiter supplies explicit push/pop
// indices; this block stores return addresses, returns predictions with one
// cycle of latency, and tracks occupancy plus sticky overflow/underflow flags.
//
// Ports:
//   clk, nreset                 : clock (rising edge), async active-low reset
//   enable                      : global qualifier, low freezes all state
//   i_flush                     : clears occupancy, valid and sticky flags
//   i_push, i_push_addr         : write request and index (low PTR bits used)
//   i_push_data                 : return address to store
//   i_pop, i_pop_addr           : read request and index (low PTR bits used)
//   o_pop_data, o_pop_valid     : predicted return address + 1-cycle qualifier
//   o_occupancy                 : live entries, 0..RAS_DEPTH
//   o_empty, o_full             : occupancy == 0 / == RAS_DEPTH
//   o_overflow, o_underflow     : sticky error flags
//
// Macro RISCV_RAS_BYPASS_EN: forward push data to a same-cycle pop of the
// same index (otherwise the old entry is returned).
// -----------------------------------------------------------------------------
module riscv_ras_stack
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = RAS_ADDR_WIDTH,
  parameter int RAS_DEPTH  = RAS_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          enable,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [ADDR_WIDTH-1:0]         i_push_addr,
  input  logic [ADDR_WIDTH-1:0]         i_pop_addr,
  input  logic [ADDR_WIDTH-1:0]         i_push_data,
  output logic [ADDR_WIDTH-1:0]         o_pop_data,
  output logic                          o_pop_valid,
  output logic [$clog2(RAS_DEPTH):0]    o_occupancy,
  output logic                          o_empty,
  output logic                          o_full,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int PTR_WIDTH = $clog2(RAS_DEPTH);
  localparam logic [PTR_WIDTH:0] OCC_FULL = (PTR_WIDTH+1)'(RAS_DEPTH);
  localparam logic [PTR_WIDTH:0] OCC_ONE  = (PTR_WIDTH+1)'(1);

  logic [PTR_WIDTH:0] occ_q, occ_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               valid_q, valid_d;
  logic               is_empty, is_full;
  logic               push_ok, pop_ok;
  logic               unused_addr_bits;

  // Index arithmetic wraps modulo RAS_DEPTH, so the upper index bits are
  // intentionally ignored.
  assign unused_addr_bits = ^{i_push_addr[ADDR_WIDTH-1:PTR_WIDTH],
                              i_pop_addr[ADDR_WIDTH-1:PTR_WIDTH]};

  assign is_empty = (occ_q == '0);
  assign is_full  = (occ_q == OCC_FULL);

  // Flush wins over push/pop; a pop only reads when something is live.
  assign push_ok = i_push && enable && !i_flush;
  assign pop_ok  = i_pop  && enable && !i_flush && !is_empty;

  riscv_ras_mem #(
    .DATA_WIDTH (ADDR_WIDTH),
    .DEPTH      (RAS_DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .nreset  (nreset),
    .i_we    (push_ok),
    .i_waddr (i_push_addr[PTR_WIDTH-1:0]),
    .i_wdata (i_push_data),
    .i_re    (pop_ok),
    .i_raddr (i_pop_addr[PTR_WIDTH-1:0]),
    .o_rdata (o_pop_data)
  );

  // A push at full still writes (the wrapped index overwrites the oldest
  // entry) but occupancy saturates and the overflow flag sticks. A push and
  // pop together leave occupancy unchanged.
  always_comb begin
    occ_d   = occ_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    valid_d = pop_ok;
    if (enable) begin
      if (i_flush) begin
        occ_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end else begin
        if (i_pop && is_empty) begin
          unf_d = 1'b1;
        end
        if (i_push && !i_pop) begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            occ_d = occ_q + OCC_ONE;
          end
        end else if (pop_ok && !i_push) begin
          occ_d = occ_q - OCC_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
    end
  end

  assign o_pop_valid = valid_q;
  assign o_occupancy = occ_q;
  assign o_empty     = is_empty;
  assign o_full      = is_full;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_riscv_ras_stack.sv
// -----------------------------------------------------------------------------
// tb_riscv_ras_stack
// Self-checking bench for riscv_ras_stack at default parameters. A behavioural
// model (plain array + counters) tracks the expected outputs; a negedge
// process compares every output each cycle, and directed sequences add
// hand-computed literal expectations.
// Honours RISCV_RAS_BYPASS_EN for the collision case.
// -----------------------------------------------------------------------------
module tb_riscv_ras_stack;

  localparam int AW    = 64;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          nreset;
  logic          enable;
  logic          i_flush;
  logic          i_push;
  logic          i_pop;
  logic [AW-1:0] i_push_addr;
  logic [AW-1:0] i_pop_addr;
  logic [AW-1:0] i_push_data;
  logic [AW-1:0] o_pop_data;
  logic          o_pop_valid;
  logic [4:0]    o_occupancy;
  logic          o_empty;
  logic          o_full;
  logic          o_overflow;
  logic          o_underflow;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  // Model state
  logic [AW-1:0] m_mem [DEPTH];
  int            m_occ;
  bit            m_ovf, m_unf, m_valid;
  logic [AW-1:0] m_data;

  riscv_ras_stack dut (
    .clk         (clk),
    .nreset      (nreset),
    .enable      (enable),
    .i_flush     (i_flush),
    .i_push      (i_push),
    .i_pop       (i_pop),
    .i_push_addr (i_push_addr),
    .i_pop_addr  (i_pop_addr),
    .i_push_data (i_push_data),
    .o_pop_data  (o_pop_data),
    .o_pop_valid (o_pop_valid),
    .o_occupancy (o_occupancy),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic compareField(input string name, input logic [AW-1:0] act,
                              input logic [AW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_occ   = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  // Applies one clock edge worth of stack rules to the model.
  task automatic modelStep();
    int wi, ri;
    wi = int'(i_push_addr % DEPTH);
    ri = int'(i_pop_addr % DEPTH);
    m_valid = 1'b0;
    if (!enable) return;
    if (i_flush) begin
      m_occ = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    if (i_pop) begin
      if (m_occ == 0) begin
        m_unf = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_data  = m_mem[ri];
`ifdef RISCV_RAS_BYPASS_EN
        if (i_push && wi == ri) m_data = i_push_data;
`endif
      end
    end
    if (i_push) m_mem[wi] = i_push_data;
    if (i_push && !i_pop) begin
      if (m_occ == DEPTH) m_ovf = 1'b1;
      else m_occ++;
    end else if (i_pop && !i_push && m_occ > 0) begin
      m_occ--;
    end
  endtask

  task automatic checkOutput();
    compareField("pop_valid", AW'(o_pop_valid), AW'(m_valid));
    compareField("pop_data", o_pop_data, m_data);
    compareField("occupancy", AW'(o_occupancy), AW'(m_occ));
    compareField("empty", AW'(o_empty), AW'(m_occ == 0));
    compareField("full", AW'(o_full), AW'(m_occ == DEPTH));
    compareField("overflow", AW'(o_overflow), AW'(m_ovf));
    compareField("underflow", AW'(o_underflow), AW'(m_unf));
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  // Drives one cycle of inputs, then advances the model past the edge.
  task automatic applyStimulus(input bit en, input bit fl, input bit pu, input bit po,
                               input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                               input logic [AW-1:0] wd);
    enable      = en;
    i_flush     = fl;
    i_push      = pu;
    i_pop       = po;
    i_push_addr = wa;
    i_pop_addr  = ra;
    i_push_data = wd;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doPush(input logic [AW-1:0] wa, input logic [AW-1:0] wd);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, wa, '0, wd);
  endtask

  task automatic doPop(input logic [AW-1:0] ra);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, ra, '0);
  endtask

  task automatic doIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic doFlush();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  logic [AW-1:0] bypass_exp;

  initial begin
    nreset      = 1'b0;
    enable      = 1'b0;
    i_flush     = 1'b0;
    i_push      = 1'b0;
    i_pop       = 1'b0;
    i_push_addr = '0;
    i_pop_addr  = '0;
    i_push_data = '0;
    modelReset();
    #12;
    check_en = 1'b1;
    compareField("lit_reset_occ", AW'(o_occupancy), 64'd0);
    compareField("lit_reset_empty", AW'(o_empty), 64'd1);
    compareField("lit_reset_full", AW'(o_full), 64'd0);
    compareField("lit_reset_valid", AW'(o_pop_valid), 64'd0);
    compareField("lit_reset_data", o_pop_data, 64'd0);
    #10 nreset = 1'b1;

    // Basic push then pop with one-cycle latency
    doPush(0, 64'h1000);
    compareField("lit_push_occ", AW'(o_occupancy), 64'd1);
    doPop(0);
    compareField("lit_pop_valid", AW'(o_pop_valid), 64'd1);
    compareField("lit_pop_data", o_pop_data, 64'h1000);
    compareField("lit_pop_occ", AW'(o_occupancy), 64'd0);
    doIdle();
    compareField("lit_valid_pulse", AW'(o_pop_valid), 64'd0);

    // Pop when empty: no pulse, sticky underflow cleared by flush
    doPop(2);
    compareField("lit_unf_valid", AW'(o_pop_valid), 64'd0);
    compareField("lit_unf_flag", AW'(o_underflow), 64'd1);
    compareField("lit_unf_hold", o_pop_data, 64'h1000);
    doIdle();
    compareField("lit_unf_sticky", AW'(o_underflow), 64'd1);
    doFlush();
    compareField("lit_unf_clear", AW'(o_underflow), 64'd0);

    // Seventeen pushes: idx 0..15 then 16 (wraps to 0)
    for (int i = 0; i <= DEPTH; i++) doPush(AW'(i), 64'hA000 + AW'(i));
    compareField("lit_full_occ", AW'(o_occupancy), 64'd16);
    compareField("lit_full_flag", AW'(o_full), 64'd1);
    compareField("lit_ovf_flag", AW'(o_overflow), 64'd1);
    doPop(0);
    compareField("lit_wrap_data", o_pop_data, 64'hA010);
    compareField("lit_wrap_occ", AW'(o_occupancy), 64'd15);
    doFlush();
    compareField("lit_ovf_clear", AW'(o_overflow), 64'd0);

    // Same-index push and pop
    doPush(3, 64'h1111);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3, 3, 64'h2000);
`ifdef RISCV_RAS_BYPASS_EN
    bypass_exp = 64'h2000;
`else
    bypass_exp = 64'h1111;
`endif
    compareField("lit_collide_data", o_pop_data, bypass_exp);
    compareField("lit_collide_occ", AW'(o_occupancy), 64'd1);

    // Different-index push and pop together
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 7, 3, 64'h7777);
    compareField("lit_dual_data", o_pop_data, 64'h2000);

    // Push with flush at occupancy five
    doFlush();
    for (int i = 0; i < 5; i++) doPush(AW'(8 + i), 64'hB000 + AW'(i));
    compareField("lit_five_occ", AW'(o_occupancy), 64'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 13, 0, 64'hDEAD);
    compareField("lit_pflush_occ", AW'(o_occupancy), 64'd0);
    compareField("lit_pflush_valid", AW'(o_pop_valid), 64'd0);

    // Upper index bits ignored
    doPush(64'h25, 64'hC5);
    doPop(5);
    compareField("lit_upper_data", o_pop_data, 64'hC5);

    // Enable low freezes everything
    doPush(1, 64'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 64'h99);
    compareField("lit_frozen_occ", AW'(o_occupancy), 64'd1);
    compareField("lit_frozen_valid", AW'(o_pop_valid), 64'd0);
    doPop(1);
    compareField("lit_frozen_data", o_pop_data, 64'h77);

    // Reset arriving one cycle after a pop discards it
    doPush(2, 64'h55);
    doPop(2);
    compareField("lit_prereset_valid", AW'(o_pop_valid), 64'd1);
    enable  = 1'b1;
    i_flush = 1'b0;
    i_push  = 1'b0;
    i_pop   = 1'b0;
    #2 nreset = 1'b0;
    modelReset();
    #1;
    compareField("lit_rst_valid", AW'(o_pop_valid), 64'd0);
    compareField("lit_rst_occ", AW'(o_occupancy), 64'd0);
    compareField("lit_rst_data", o_pop_data, 64'd0);
    @(posedge clk);
    #2 nreset = 1'b1;
    doIdle();
    compareField("lit_postrst_valid", AW'(o_pop_valid), 64'd0);
    doIdle();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
